// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
//
// Parametrised register file for the pipelined MIPS core: a DATA_W x 2^ADDR_W
// array with two combinational read ports and one synchronous write port. A
// per-register pending bit (scoreboard) tracks in-flight producers so that
// decode can detect read-after-write hazards.
//
// Parameters
//   DATA_W    register width in bits
//   ADDR_W    address width, depth = 2^ADDR_W
//   ZERO_REG  1: entry 0 reads as 0 and ignores writes and claims
//   BYPASS    1: same-cycle write data is forwarded to the read ports
//
// Ports
//   i_clk         clock, all state updates on the rising edge
//   i_rst_n       synchronous active-low reset (clears mem and pend)
//   i_raddr1/2    read addresses
//   o_rdata1/2    read data (combinational)
//   o_busy1/2     addressed register has an outstanding producer
//   i_we          write enable (writeback stage)
//   i_waddr       write address
//   i_wdata       write data
//   i_claim       mark i_claim_addr as pending (issue stage)
//   i_claim_addr  destination address being claimed
//
// There is no handshake and no back-pressure; stall generation from the busy
// outputs is left to the pipeline control.
// -----------------------------------------------------------------------------
module reg_file_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [ADDR_W-1:0] i_raddr1,
    input  logic [ADDR_W-1:0] i_raddr2,
    output logic [DATA_W-1:0] o_rdata1,
    output logic [DATA_W-1:0] o_rdata2,
    output logic              o_busy1,
    output logic              o_busy2,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_claim,
    input  logic [ADDR_W-1:0] i_claim_addr
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  pend_q;
    logic [DEPTH-1:0]  pend_d;

    logic wr_ok;
    logic claim_ok;
    logic zero1, zero2;
    logic byp1, byp2;

    // Writes and claims aimed at the hardwired zero entry are dropped here, so
    // mem_q[0] and pend_q[0] stay at their reset value of 0.
    assign wr_ok    = i_we    && !(ZERO_REG && (i_waddr == '0));
    assign claim_ok = i_claim && !(ZERO_REG && (i_claim_addr == '0));

    // Write clears the pending bit first, then a claim sets it: when both hit
    // the same register the claim wins because a newer producer was issued.
    always_comb begin
        pend_d = pend_q;
        if (wr_ok) begin
            pend_d[i_waddr] = 1'b0;
        end
        if (claim_ok) begin
            pend_d[i_claim_addr] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            if (wr_ok) begin
                mem_q[i_waddr] <= i_wdata;
            end
            pend_q <= pend_d;
        end
    end

    // Read side. Bypass is suppressed during reset because the write it would
    // forward is going to be discarded at the edge.
    assign zero1 = ZERO_REG && (i_raddr1 == '0);
    assign zero2 = ZERO_REG && (i_raddr2 == '0);
    assign byp1  = BYPASS && i_rst_n && i_we && (i_waddr == i_raddr1) && !zero1;
    assign byp2  = BYPASS && i_rst_n && i_we && (i_waddr == i_raddr2) && !zero2;

    always_comb begin
        o_rdata1 = mem_q[i_raddr1];
        o_busy1  = pend_q[i_raddr1];
        if (zero1) begin
            o_rdata1 = '0;
            o_busy1  = 1'b0;
        end else if (byp1) begin
            // The producer is completing this cycle, so the hazard is resolved.
            o_rdata1 = i_wdata;
            o_busy1  = 1'b0;
        end
    end

    always_comb begin
        o_rdata2 = mem_q[i_raddr2];
        o_busy2  = pend_q[i_raddr2];
        if (zero2) begin
            o_rdata2 = '0;
            o_busy2  = 1'b0;
        end else if (byp2) begin
            o_rdata2 = i_wdata;
            o_busy2  = 1'b0;
        end
    end

endmodule
